// File: rtl/asic_sweep_sequencer.sv
// Sweeps a programmable DAC code range through the ASIC function interface and
// stores each returned XADC result at a sequential result-memory address.
// Optional per-code averaging is built when SWEEP_AVG_EN is defined.
module asic_sweep_sequencer #(
    parameter int ADDR_WIDTH    = 15,
    parameter int SETTLE_CYCLES = 16,
    parameter int AVG_LOG2      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sweep_start,
    input  logic                  abort,
    input  logic [15:0]           cfg_start_code,
    input  logic [15:0]           cfg_end_code,
    input  logic [15:0]           cfg_step,
    output logic                  sweep_busy,
    output logic                  sweep_done,
    output logic [ADDR_WIDTH:0]   sample_count,
    output logic                  fi_start,
    output logic [15:0]           fi_data_in,
    input  logic                  fi_data_valid,
    input  logic [15:0]           fi_data_out,
    output logic                  res_we,
    output logic [ADDR_WIDTH-1:0] res_addr,
    output logic [15:0]           res_wdata
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETTLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_WRITE,
        S_NEXT,
        S_FINISH,
        S_DRAIN
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           code_q, code_d;
    logic [15:0]           end_q, end_d;
    logic [15:0]           step_q, step_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [SW-1:0]         settle_q, settle_d;
    logic                  fi_start_q, res_we_q, busy_q, done_q;
    logic [16:0]           next_code;
    logic                  last_code;

`ifdef SWEEP_AVG_EN
    localparam int ACC_W = 16 + AVG_LOG2;
    localparam int RW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [RW-1:0] REP_LAST = RW'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
    logic [RW-1:0]    rep_q, rep_d;
`else
    logic unused_avg;
    assign unused_avg = (AVG_LOG2 != 0);
`endif

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        end_d    = end_q;
        step_d   = step_q;
        addr_d   = addr_q;
        count_d  = count_q;
        wdata_d  = wdata_q;
        settle_d = settle_q;
`ifdef SWEEP_AVG_EN
        acc_d    = acc_q;
        rep_d    = rep_q;
        acc_sum  = acc_q + ACC_W'(fi_data_out);
`endif
        // The 17-bit sum exposes a wrap past 0xFFFF as well as an overshoot of the end code.
        next_code = {1'b0, code_q} + {1'b0, step_q};
        last_code = (next_code > {1'b0, end_q}) || next_code[16] || (addr_q == '1);

        case (state_q)
            S_IDLE: begin
                if (sweep_start) begin
                    code_d  = cfg_start_code;
                    end_d   = cfg_end_code;
                    step_d  = (cfg_step == 16'd0) ? 16'd1 : cfg_step;
                    addr_d  = '0;
                    count_d = '0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_FINISH;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = S_ISSUE;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            S_ISSUE: begin
                state_d = abort ? S_DRAIN : S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (abort) begin
                    state_d = S_DRAIN;
                end else if (!fi_data_valid) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (abort) begin
                    state_d = S_DRAIN;
                end else if (fi_data_valid) begin
`ifdef SWEEP_AVG_EN
                    if (rep_q == REP_LAST) begin
                        wdata_d = acc_sum[AVG_LOG2 +: 16];
                        count_d = count_q + (ADDR_WIDTH + 1)'(1);
                        state_d = S_WRITE;
                    end else begin
                        acc_d   = acc_sum;
                        rep_d   = rep_q + RW'(1);
                        state_d = S_ISSUE;
                    end
`else
                    wdata_d = fi_data_out;
                    count_d = count_q + (ADDR_WIDTH + 1)'(1);
                    state_d = S_WRITE;
`endif
                end
            end
            S_WRITE: begin
                state_d = abort ? S_FINISH : S_NEXT;
            end
            S_NEXT: begin
                if (abort || last_code) begin
                    state_d = S_FINISH;
                end else begin
                    code_d  = next_code[15:0];
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = S_SETTLE;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (fi_data_valid) begin
                    state_d = S_FINISH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Every entry into SETTLE restarts the settle count and any partial average.
        if ((state_d == S_SETTLE) && (state_q != S_SETTLE)) begin
            settle_d = '0;
`ifdef SWEEP_AVG_EN
            acc_d    = '0;
            rep_d    = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            code_q     <= '0;
            end_q      <= '0;
            step_q     <= '0;
            wdata_q    <= '0;
            addr_q     <= '0;
            count_q    <= '0;
            settle_q   <= '0;
            fi_start_q <= 1'b0;
            res_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SWEEP_AVG_EN
            acc_q      <= '0;
            rep_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            end_q      <= end_d;
            step_q     <= step_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            settle_q   <= settle_d;
            // Strobes are registered from the next state so each is high exactly while in its state.
            fi_start_q <= (state_d == S_ISSUE);
            res_we_q   <= (state_d == S_WRITE);
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_FINISH);
`ifdef SWEEP_AVG_EN
            acc_q      <= acc_d;
            rep_q      <= rep_d;
`endif
        end
    end

    assign sweep_busy   = busy_q;
    assign sweep_done   = done_q;
    assign sample_count = count_q;
    assign fi_start     = fi_start_q;
    assign fi_data_in   = code_q;
    assign res_we       = res_we_q;
    assign res_addr     = addr_q;
    assign res_wdata    = wdata_q;

endmodule

// File: tb/tb_asic_sweep_sequencer.sv
// Randomised self-checking bench for asic_sweep_sequencer with a function-interface
// responder and a code-list reference model; follows SWEEP_AVG_EN when defined.
`timescale 1ns/1ps
module tb_asic_sweep_sequencer;

    localparam int AW     = 3;
    localparam int SETTLE = 4;
`ifdef SWEEP_AVG_EN
    localparam int AVG_L  = 2;
`else
    localparam int AVG_L  = 0;
`endif
    localparam int REPS   = 1 << AVG_L;

    logic          clk;
    logic          rst_n;
    logic          sweep_start;
    logic          abort;
    logic [15:0]   cfg_start_code;
    logic [15:0]   cfg_end_code;
    logic [15:0]   cfg_step;
    logic          sweep_busy;
    logic          sweep_done;
    logic [AW:0]   sample_count;
    logic          fi_start;
    logic [15:0]   fi_data_in;
    logic          fi_data_valid;
    logic [15:0]   fi_data_out;
    logic          res_we;
    logic [AW-1:0] res_addr;
    logic [15:0]   res_wdata;

    asic_sweep_sequencer #(
        .ADDR_WIDTH   (AW),
        .SETTLE_CYCLES(SETTLE),
        .AVG_LOG2     (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sweep_start   (sweep_start),
        .abort         (abort),
        .cfg_start_code(cfg_start_code),
        .cfg_end_code  (cfg_end_code),
        .cfg_step      (cfg_step),
        .sweep_busy    (sweep_busy),
        .sweep_done    (sweep_done),
        .sample_count  (sample_count),
        .fi_start      (fi_start),
        .fi_data_in    (fi_data_in),
        .fi_data_valid (fi_data_valid),
        .fi_data_out   (fi_data_out),
        .res_we        (res_we),
        .res_addr      (res_addr),
        .res_wdata     (res_wdata)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    int wr_addr_q [$];
    int wr_data_q [$];
    int wr_lat_q  [$];
    int exp_code_q[$];
    int done_cnt, done_cyc, start_cnt, first_start_cyc, last_wr_cyc, start_cyc;
    int rise_cyc, stab_err;
    int hold_hi, low_len, resp_mode;
    bit rand_delays, new_sweep;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no end of test, expected finish before 500 us");
        $fatal(1, "[TB] watchdog expired");
    end

    // Interface response for conversion k of a code: mode 0 inverts the code, mode 1 ramps.
    function automatic int resp_val(input int code, input int k, input int mode);
        if (mode == 0) return (code ^ 'hFFFF) & 'hFFFF;
        return (code & 'hFFF) + 10 + k;
    endfunction

    function automatic int exp_data(input int code, input int mode);
        int sum;
        sum = 0;
        for (int k = 0; k < REPS; k++) sum += resp_val(code, k, mode);
        return (sum >> AVG_L) & 'hFFFF;
    endfunction

    // Reference sweep: list of codes visited, derived from start/end/step rules.
    task automatic build_model(input int s, input int e, input int st);
        int step;
        int c;
        exp_code_q.delete();
        step = (st == 0) ? 1 : st;
        c = s;
        forever begin
            exp_code_q.push_back(c);
            if ((c + step > e) || (c + step > 65535) || (exp_code_q.size() == (1 << AW))) break;
            c = c + step;
        end
    endtask

    // Function-interface model: valid idles high, drops after an optional delay, returns with data.
    initial begin : responder
        int cur, last, k, hold, low;
        fi_data_valid = 1'b1;
        fi_data_out   = 16'd0;
        last = -1;
        k = 0;
        forever begin
            @(negedge clk);
            if (fi_start === 1'b1) begin
                cur = int'(fi_data_in);
                if (new_sweep || cur != last) k = 0;
                else k = k + 1;
                new_sweep = 1'b0;
                last = cur;
                hold = rand_delays ? int'($urandom_range(0, 3)) : hold_hi;
                low  = rand_delays ? int'($urandom_range(1, 5)) : low_len;
                repeat (hold) begin
                    @(negedge clk);
                    if (fi_data_in !== cur[15:0]) stab_err++;
                end
                @(negedge clk);
                fi_data_valid = 1'b0;
                repeat (low) begin
                    @(negedge clk);
                    if (fi_data_in !== cur[15:0]) stab_err++;
                end
                fi_data_out   = 16'(resp_val(cur, k, resp_mode));
                fi_data_valid = 1'b1;
                rise_cyc      = cyc;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (res_we === 1'b1) begin
                wr_addr_q.push_back(int'(res_addr));
                wr_data_q.push_back(int'(res_wdata));
                wr_lat_q.push_back(cyc - rise_cyc);
                last_wr_cyc = cyc;
            end
            if (sweep_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (fi_start === 1'b1) begin
                start_cnt++;
                if (first_start_cyc < 0) first_start_cyc = cyc;
            end
        end
    end

    task automatic clear_monitor();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_lat_q.delete();
        done_cnt = 0;
        done_cyc = -1;
        start_cnt = 0;
        first_start_cyc = -1;
        last_wr_cyc = -1;
        stab_err = 0;
    endtask

    task automatic start_sweep(input int s, input int e, input int st);
        clear_monitor();
        @(negedge clk);
        cfg_start_code = 16'(s);
        cfg_end_code   = 16'(e);
        cfg_step       = 16'(st);
        new_sweep      = 1'b1;
        sweep_start    = 1'b1;
        start_cyc      = cyc;
        @(negedge clk);
        sweep_start    = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
        checks++;
        if (done_cnt == 0) begin
            fails++;
            $display("[TB] FAIL %s timeout: observed no sweep_done, expected one within 3000 cycles", name);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic do_sweep(input int s, input int e, input int st, input bit disturb, input string name);
        start_sweep(s, e, st);
        if (disturb) begin
            cfg_start_code = 16'($urandom);
            cfg_end_code   = 16'($urandom);
            cfg_step       = 16'($urandom);
            @(negedge clk);
            sweep_start = 1'b1;
            @(negedge clk);
            sweep_start = 1'b0;
        end
        wait_done(name);
    endtask

    task automatic test_reset();
        int obs [8];
        string nm [8];
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        nm = '{"sweep_busy", "sweep_done", "fi_start", "res_we",
               "fi_data_in", "res_addr", "res_wdata", "sample_count"};
        obs = '{int'(sweep_busy), int'(sweep_done), int'(fi_start), int'(res_we),
                int'(fi_data_in), int'(res_addr), int'(res_wdata), int'(sample_count)};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs[i] !== 0) begin
                fails++;
                $display("[TB] FAIL reset %s: observed %0h, expected 0", nm[i], obs[i]);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int exp_d [4];
        exp_d = '{'hEFFF, 'hEFFE, 'hEFFD, 'hEFFC};
        resp_mode = 0; rand_delays = 0; hold_hi = 0; low_len = 2;
        do_sweep('h1000, 'h1003, 1, 0, "basic");
        checks++;
        if (wr_data_q.size() != 4) begin
            fails++;
            $display("[TB] FAIL basic write count: observed %0d, expected 4", wr_data_q.size());
        end
        for (int i = 0; i < 4 && i < wr_data_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== i || wr_data_q[i] !== exp_d[i] || wr_lat_q[i] !== 1) begin
                fails++;
                $display("[TB] FAIL basic write %0d: observed addr %0d data %0h lat %0d, expected addr %0d data %0h lat 1",
                         i, wr_addr_q[i], wr_data_q[i], wr_lat_q[i], i, exp_d[i]);
            end
        end
        checks++;
        if (sample_count !== 4 || done_cnt !== 1 || sweep_busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL basic end state: observed count %0d done %0d busy %0b, expected 4 1 0",
                     sample_count, done_cnt, sweep_busy);
        end
        checks++;
        if (first_start_cyc - start_cyc !== SETTLE + 1 || start_cnt !== 4 * REPS) begin
            fails++;
            $display("[TB] FAIL basic issue timing: observed latency %0d starts %0d, expected %0d %0d",
                     first_start_cyc - start_cyc, start_cnt, SETTLE + 1, 4 * REPS);
        end
        checks++;
        if (done_cyc - last_wr_cyc < 1 || done_cyc - last_wr_cyc > 2) begin
            fails++;
            $display("[TB] FAIL basic done timing: observed %0d cycles after last write, expected 1..2",
                     done_cyc - last_wr_cyc);
        end
    endtask

    task automatic test_boundaries();
        int cs [5];
        int ce [5];
        int cst[5];
        cs  = '{'hFFF0, 5, 9, 0,   'hFFFE};
        ce  = '{'hFFFF, 7, 3, 100, 'hFFFF};
        cst = '{'h10,   0, 2, 1,   1};
        resp_mode = 0; rand_delays = 0; hold_hi = 1; low_len = 1;
        for (int t = 0; t < 5; t++) begin
            build_model(cs[t], ce[t], cst[t]);
            do_sweep(cs[t], ce[t], cst[t], 0, "boundary");
            checks++;
            if (wr_data_q.size() != exp_code_q.size() || sample_count !== exp_code_q.size() || done_cnt !== 1) begin
                fails++;
                $display("[TB] FAIL boundary %0d counts: observed writes %0d count %0d done %0d, expected %0d %0d 1",
                         t, wr_data_q.size(), sample_count, done_cnt, exp_code_q.size(), exp_code_q.size());
            end
            for (int i = 0; i < exp_code_q.size() && i < wr_data_q.size(); i++) begin
                checks++;
                if (wr_addr_q[i] !== i || wr_data_q[i] !== exp_data(exp_code_q[i], 0)) begin
                    fails++;
                    $display("[TB] FAIL boundary %0d write %0d: observed addr %0d data %0h, expected addr %0d data %0h",
                             t, i, wr_addr_q[i], wr_data_q[i], i, exp_data(exp_code_q[i], 0));
                end
            end
        end
    endtask

    task automatic test_handshake();
        resp_mode = 0; rand_delays = 0; hold_hi = 3; low_len = 3;
        build_model('h40, 'h42, 1);
        do_sweep('h40, 'h42, 1, 0, "handshake");
        checks++;
        if (stab_err !== 0 || wr_data_q.size() != 3) begin
            fails++;
            $display("[TB] FAIL handshake: observed stability errors %0d writes %0d, expected 0 3",
                     stab_err, wr_data_q.size());
        end
        for (int i = 0; i < wr_data_q.size() && i < exp_code_q.size(); i++) begin
            checks++;
            if (wr_lat_q[i] !== 1 || wr_data_q[i] !== exp_data(exp_code_q[i], 0)) begin
                fails++;
                $display("[TB] FAIL handshake write %0d: observed lat %0d data %0h, expected lat 1 data %0h",
                         i, wr_lat_q[i], wr_data_q[i], exp_data(exp_code_q[i], 0));
            end
        end
    endtask

    task automatic test_abort_settle();
        resp_mode = 0; rand_delays = 0; hold_hi = 0; low_len = 2;
        start_sweep('h100, 'h110, 1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done("abort_settle");
        checks++;
        if (wr_data_q.size() != 0 || start_cnt !== 0 || done_cnt !== 1 || sample_count !== 0 || sweep_busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL abort_settle: observed writes %0d starts %0d done %0d count %0d busy %0b, expected 0 0 1 0 0",
                     wr_data_q.size(), start_cnt, done_cnt, sample_count, sweep_busy);
        end
    endtask

    task automatic test_abort_wait_done();
        resp_mode = 0; rand_delays = 0; hold_hi = 0; low_len = 6;
        start_sweep('h20, 'h30, 1);
        for (int i = 0; i < 2000 && start_cnt < REPS + 1; i++) @(negedge clk);
        for (int i = 0; i < 50 && fi_data_valid !== 1'b0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done("abort_wait_done");
        checks++;
        if (wr_data_q.size() != 1 || sample_count !== 1 || done_cnt !== 1 || start_cnt !== REPS + 1) begin
            fails++;
            $display("[TB] FAIL abort_wait_done counts: observed writes %0d count %0d done %0d starts %0d, expected 1 1 1 %0d",
                     wr_data_q.size(), sample_count, done_cnt, start_cnt, REPS + 1);
        end
        checks++;
        if (done_cyc - rise_cyc !== 1) begin
            fails++;
            $display("[TB] FAIL abort_wait_done timing: observed done %0d cycles after valid, expected 1",
                     done_cyc - rise_cyc);
        end
        checks++;
        if (wr_data_q.size() > 0 && wr_data_q[0] !== exp_data('h20, 0)) begin
            fails++;
            $display("[TB] FAIL abort_wait_done data: observed %0h, expected %0h", wr_data_q[0], exp_data('h20, 0));
        end
    endtask

    task automatic test_reset_mid();
        int obs [8];
        resp_mode = 0; rand_delays = 0; hold_hi = 0; low_len = 1;
        start_sweep('h200, 'h205, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        obs = '{int'(sweep_busy), int'(sweep_done), int'(fi_start), int'(res_we),
                int'(fi_data_in), int'(res_addr), int'(res_wdata), int'(sample_count)};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs[i] !== 0) begin
                fails++;
                $display("[TB] FAIL reset_mid output %0d: observed %0h, expected 0", i, obs[i]);
            end
        end
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (done_cnt !== 0 || start_cnt !== 0 || sweep_busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_mid quiet: observed done %0d starts %0d busy %0b, expected 0 0 0",
                     done_cnt, start_cnt, sweep_busy);
        end
        build_model('h300, 'h302, 1);
        do_sweep('h300, 'h302, 1, 0, "reset_mid_rerun");
        checks++;
        if (wr_data_q.size() != 3 || done_cnt !== 1 || wr_data_q[2] !== exp_data(exp_code_q[2], 0)) begin
            fails++;
            $display("[TB] FAIL reset_mid rerun: observed writes %0d done %0d, expected 3 1", wr_data_q.size(), done_cnt);
        end
    endtask

`ifdef SWEEP_AVG_EN
    task automatic test_avg();
        resp_mode = 1; rand_delays = 0; hold_hi = 0; low_len = 1;
        do_sweep(0, 0, 1, 0, "avg");
        checks++;
        if (wr_data_q.size() != 1 || start_cnt !== 4 || wr_data_q[0] !== 11) begin
            fails++;
            $display("[TB] FAIL avg: observed writes %0d starts %0d data %0d, expected 1 4 11",
                     wr_data_q.size(), start_cnt, wr_data_q.size() > 0 ? wr_data_q[0] : -1);
        end
        resp_mode = 0;
    endtask
`endif

    task automatic test_random();
        int s, e, st;
        resp_mode = 0; rand_delays = 1;
        for (int n = 0; n < 12; n++) begin
            s = int'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) == 0) st = int'($urandom_range(0, 65535));
            else st = int'($urandom_range(0, 5));
            if ($urandom_range(0, 2) == 0) e = int'($urandom_range(0, 65535));
            else begin
                e = s + int'($urandom_range(0, 12));
                if (e > 65535) e = 65535;
            end
            build_model(s, e, st);
            do_sweep(s, e, st, 1, "random");
            checks++;
            if (wr_data_q.size() != exp_code_q.size() || sample_count !== exp_code_q.size() ||
                done_cnt !== 1 || stab_err !== 0 || start_cnt !== exp_code_q.size() * REPS) begin
                fails++;
                $display("[TB] FAIL random %0d (s=%0h e=%0h st=%0h): observed writes %0d count %0d done %0d stab %0d starts %0d, expected %0d %0d 1 0 %0d",
                         n, s, e, st, wr_data_q.size(), sample_count, done_cnt, stab_err, start_cnt,
                         exp_code_q.size(), exp_code_q.size(), exp_code_q.size() * REPS);
            end
            for (int i = 0; i < exp_code_q.size() && i < wr_data_q.size(); i++) begin
                checks++;
                if (wr_addr_q[i] !== i || wr_data_q[i] !== exp_data(exp_code_q[i], 0) || wr_lat_q[i] !== 1) begin
                    fails++;
                    $display("[TB] FAIL random %0d write %0d: observed addr %0d data %0h lat %0d, expected addr %0d data %0h lat 1",
                             n, i, wr_addr_q[i], wr_data_q[i], wr_lat_q[i], i, exp_data(exp_code_q[i], 0));
                end
            end
        end
        rand_delays = 0;
    endtask

    initial begin
        rst_n          = 1'b0;
        sweep_start    = 1'b0;
        abort          = 1'b0;
        cfg_start_code = 16'd0;
        cfg_end_code   = 16'd0;
        cfg_step       = 16'd0;
        hold_hi        = 0;
        low_len        = 1;
        resp_mode      = 0;
        rand_delays    = 1'b0;
        new_sweep      = 1'b0;
        rise_cyc       = 0;
        clear_monitor();

        test_reset();
        test_basic();
        test_boundaries();
        test_handshake();
        test_abort_settle();
        test_abort_wait_done();
        test_reset_mid();
`ifdef SWEEP_AVG_EN
        test_avg();
`endif
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
